pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register for the siiCpu core. It replaces fixed free-running inter-stage registers with a valid/ready handshake, synchronous flush and back-pressure, and an optional skid buffer. The block sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries the PC, the instruction word and an opaque, width-configurable control/data payload.

## Interface
Parameters:
- PC_W, 32: width of the PC field.
- INSN_W, 32: width of the instruction field.
- PAYLOAD_W, 64: width of the opaque payload (alu_out, gpr_we_, dst_addr, mem_op, etc., packed by the instantiating stage).
- CNT_W, 16: width of the stall counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: reset, asynchronous, active-low.
- flush, input, 1: synchronous kill of every held entry.
- in_valid, input, 1: upstream holds a valid entry.
- in_ready, output, 1: stage accepts an entry this cycle.
- in_pc, input, PC_W: upstream PC.
- in_insn, input, INSN_W: upstream instruction.
- in_payload, input, PAYLOAD_W: upstream payload.
- out_valid, output, 1: the out_* fields hold a valid entry.
- out_ready, input, 1: downstream consumes the entry this cycle.
- out_pc, output, PC_W: registered PC.
- out_insn, output, INSN_W: registered instruction.
- out_payload, output, PAYLOAD_W: registered payload.
- stall_cnt, output, CNT_W: count of cycles with out_valid=1 and out_ready=0.

## Operation
- Accept: in_valid && in_ready at the edge. Consume: out_valid && out_ready at the edge.
- Reset (asynchronous, any time, including mid-transfer): every output goes to 0, including stall_cnt. Any held entry is lost. in_ready is 0 during reset and 1 from the first edge after deassertion.
- Base mode, without the macro: one entry register, states EMPTY and FULL.
  - in_ready = !out_valid || out_ready, combinational.
  - EMPTY to FULL on accept.
  - FULL stays FULL on consume plus accept; the new entry overwrites the old one.
  - FULL to EMPTY on consume without accept.
- Flush: at the edge, all valid bits clear and the state becomes EMPTY. An accept in the same cycle is discarded, so flush has priority over accept. Data fields keep their old values; they are don't-care while invalid. A consume in the same cycle still counts as consumed downstream.
- stall_cnt: increments each cycle with out_valid=1 and out_ready=0. Saturates at all-ones with no wrap. Only reset clears it; flush does not.
- Ordering: entries leave in acceptance order. No entry is duplicated or dropped, except by flush or reset.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N, so out_valid=1 during cycle N+1.
- Throughput: one entry per cycle when out_ready is held at 1.
- out_* fields stay stable while out_valid=1 and out_ready=0.
- Base mode: the in_ready to out_ready path is combinational; a back-pressure chain spans all stages.

## Configuration
- Macro: SIICPU_PIPE_SKID_EN.
- Defined: a 2-entry skid buffer is used, with states EMPTY, ONE and TWO.
  - in_ready is registered: in_ready = (state != TWO). There is no combinational path from out_ready to in_ready.
  - EMPTY to ONE on accept.
  - ONE stays ONE on accept plus consume.
  - ONE to TWO on accept without consume; the new entry goes to the skid register.
  - ONE to EMPTY on consume without accept.
  - TWO to ONE on consume; the skid entry moves to the output register.
  - Accept is impossible in TWO because in_ready=0.
  - Flush from any state returns to EMPTY.
  - in_ready deasserts the cycle after the skid register fills.
- Undefined: base mode only; the skid register and its logic are absent.

## Structure
- unit/define.v gains the default widths for the parameters, and the state encodings PIPE_ST_EMPTY=2'd0, PIPE_ST_ONE=2'd1, PIPE_ST_TWO=2'd2. Base mode uses only EMPTY and ONE.
- One natural sub-module: pipe_sat_cnt, the saturating stall counter (width CNT_W, inc and clr inputs), reusable for other performance counters.
- Entry storage is a single concatenated register {pc, insn, payload}, one per slot.

## Test plan
- Reset mid-stream with out_valid=1: assert reset, so out_valid=0, out_pc=0 and stall_cnt=0 immediately. The first accept after release shows out_pc=0x100 one cycle later.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with pc 0x0 to 0x1C. out_pc follows the same sequence, 1 cycle late, with no gaps.
- Back-pressure: out_ready=0 for 5 cycles with out_valid=1. stall_cnt increases by 5, out_pc is held, and no entry is lost. With SKID_EN, in_ready drops to 0 exactly 1 cycle after the second accept.
- Flush with simultaneous accept: flush=1 and in_valid=1 with pc 0x40. Next cycle out_valid=0, and 0x40 never appears.
- Saturation: CNT_W=4 with 20 stalled cycles. stall_cnt=15 and holds.
- SKID_EN in state TWO with out_ready pulsed 1 for one cycle: the older entry leaves first, state becomes ONE, and in_ready=1 the following cycle.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: default widths and state encodings shared by the pipeline stage register.
package pipe_stage_reg_pkg;
  localparam int PIPE_PC_W = 32;
  localparam int PIPE_INSN_W = 32;
  localparam int PIPE_PAYLOAD_W = 64;
  localparam int PIPE_CNT_W = 16;
  localparam logic [1:0] PIPE_ST_EMPTY = 2'd0;
  localparam logic [1:0] PIPE_ST_ONE = 2'd1;
  localparam logic [1:0] PIPE_ST_TWO = 2'd2;
endpackage

// File: rtl/pipe_stage_reg_sat_cnt.sv
// pipe_sat_cnt: saturating up-counter with synchronous clear, reusable for performance counters.
module pipe_sat_cnt
  import pipe_stage_reg_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o = cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush and stall counter.
// Define SIICPU_PIPE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int PC_W = PIPE_PC_W,
  parameter int INSN_W = PIPE_INSN_W,
  parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [INSN_W-1:0]    in_insn,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [INSN_W-1:0]    out_insn,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     stall_cnt
);
  localparam int EW = PC_W + INSN_W + PAYLOAD_W;
  logic [1:0] st_q, st_d;
  logic [EW-1:0] out_q, out_d, in_ent;
  logic rdy_q, acc, con;
  assign in_ent = {in_pc, in_insn, in_payload};
  assign out_valid = st_q != PIPE_ST_EMPTY;
  assign {out_pc, out_insn, out_payload} = out_q;
  assign acc = in_valid && in_ready;
  assign con = out_valid && out_ready;
  // rdy_q keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rdy_q <= 1'b0;
      st_q  <= PIPE_ST_EMPTY;
      out_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      st_q  <= st_d;
      out_q <= out_d;
    end
`ifdef SIICPU_PIPE_SKID_EN
  logic [EW-1:0] skd_q, skd_d;
  assign in_ready = rdy_q && st_q != PIPE_ST_TWO;
  assign st_d = flush ? PIPE_ST_EMPTY :
                st_q == PIPE_ST_TWO ? (con ? PIPE_ST_ONE : PIPE_ST_TWO) :
                acc ? ((con || st_q == PIPE_ST_EMPTY) ? PIPE_ST_ONE : PIPE_ST_TWO) :
                con ? PIPE_ST_EMPTY : st_q;
  assign out_d = flush ? out_q :
                 (st_q == PIPE_ST_TWO && con) ? skd_q :
                 (acc && (st_q == PIPE_ST_EMPTY || con)) ? in_ent : out_q;
  assign skd_d = (!flush && acc && st_q == PIPE_ST_ONE && !con) ? in_ent : skd_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) skd_q <= '0;
    else skd_q <= skd_d;
`else
  assign in_ready = rdy_q && (!out_valid || out_ready);
  assign st_d = flush ? PIPE_ST_EMPTY : acc ? PIPE_ST_ONE : con ? PIPE_ST_EMPTY : st_q;
  assign out_d = (acc && !flush) ? in_ent : out_q;
`endif
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc_i(out_valid && !out_ready),
    .clr_i(1'b0),
    .cnt_o(stall_cnt)
  );
endmodule
